sram_bridge_master: RTL and testbench

- Initiator for the external-bus bridge conduit of the SRAM access system: drives address, byte_enable, read, write and write_data, and completes each transfer on acknowledge.
- Lets adaptive-filter datapath logic read and write the 1M x 16 SRAM through a simple valid/ready command port, with a pulsed response port.
- Sits between filter control logic and the bridge_input_conduit_* ports of the SRAM access system.
- One transfer is outstanding at a time.

---
 rtl/sram_bridge_pkg.sv | 14 +
 rtl/sram_bridge_wdog.sv | 28 ++
 rtl/sram_bridge_master.sv | 155 +++++++++++++++
 tb/tb_sram_bridge_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and default sizing for the SRAM bridge initiator (1M x 16 SRAM, byte addressed).
package sram_bridge_pkg;

  localparam int DEF_ADDR_W      = 21;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BE_W        = DEF_DATA_W / 8;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/sram_bridge_wdog.sv
// Acknowledge watchdog: counts enabled cycles since clear; o_expired flags the cycle the count
// reaches LIMIT. Combinational expiry, no backpressure.
module sram_bridge_wdog #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires in the cycle whose increment would make the count equal LIMIT.
  assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/sram_bridge_master.sv
// Valid/ready command to bridge-conduit initiator, one transfer outstanding; strobe the cycle after
// accept, pulsed response the cycle after ack. Optional ack timeout under SRAM_BRIDGE_TIMEOUT_EN.
module sram_bridge_master
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BE_W        = DEF_BE_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BE_W-1:0]   cmd_byte_en,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address,
  output logic [BE_W-1:0]   bus_byte_enable,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic              bus_acknowledge,
  input  logic [DATA_W-1:0] bus_read_data
);

  state_e            r_state, w_state_nxt;
  logic              r_cmd_ready;
  logic              r_bus_read, r_bus_write;
  logic [ADDR_W-1:0] r_bus_address;
  logic [BE_W-1:0]   r_bus_byte_enable;
  logic [DATA_W-1:0] r_bus_write_data;
  logic              r_rsp_valid, r_wr_done;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_accept, w_start, w_done, w_tmo, w_expired;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          // A write with no lanes enabled never reaches the bus.
          if (!(cmd_write && (cmd_byte_en == '0))) begin
            w_start     = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (bus_acknowledge) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cmd_ready       <= 1'b0;
      r_bus_read        <= 1'b0;
      r_bus_write       <= 1'b0;
      r_bus_address     <= '0;
      r_bus_byte_enable <= '0;
      r_bus_write_data  <= '0;
      r_rsp_valid       <= 1'b0;
      r_wr_done         <= 1'b0;
      r_rsp_data        <= '0;
    end else begin
      // Ready stays low for the cycle after a completion, forcing a strobe-low gap.
      r_cmd_ready <= (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_done && r_bus_read;
      r_wr_done   <= (w_done && r_bus_write) || (w_accept && !w_start);
      if (w_start) begin
        r_bus_address     <= cmd_addr;
        r_bus_byte_enable <= cmd_byte_en;
        r_bus_write_data  <= cmd_wdata;
        r_bus_read        <= !cmd_write;
        r_bus_write       <= cmd_write;
      end else if (w_done || w_tmo) begin
        r_bus_read  <= 1'b0;
        r_bus_write <= 1'b0;
      end
      if (w_done && r_bus_read) begin
        r_rsp_data <= bus_read_data;
      end
    end
  end

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  logic r_rsp_err;
  logic w_wdog_en;

  assign w_wdog_en = (r_state == ST_BUSY) && !bus_acknowledge;

  sram_bridge_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .i_clk    (clk_clk),
    .i_rst    (reset_reset),
    .i_clr    (w_accept),
    .i_en     (w_wdog_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_tmo;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  // Constant-false; keeps the limit referenced when the watchdog is compiled out.
  assign w_expired = (TIMEOUT_CYC < 0);
  assign rsp_err   = 1'b0;
`endif

  assign cmd_ready       = r_cmd_ready;
  assign busy            = (r_state == ST_BUSY);
  assign bus_address     = r_bus_address;
  assign bus_byte_enable = r_bus_byte_enable;
  assign bus_read        = r_bus_read;
  assign bus_write       = r_bus_write;
  assign bus_write_data  = r_bus_write_data;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign wr_done         = r_wr_done;

endmodule

// File: tb/tb_sram_bridge_master.sv
// Bench for sram_bridge_master: directed scenarios plus random transfers against an SRAM model.
module tb_sram_bridge_master;

  localparam int AW = 21;
  localparam int DW = 16;
  localparam int BW = 2;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_byte_en;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, wr_done, busy;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] bus_address;
  logic [BW-1:0] bus_byte_enable;
  logic          bus_read, bus_write, bus_acknowledge;
  logic [DW-1:0] bus_write_data, bus_read_data;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  always #5 clk_clk = ~clk_clk;

  sram_bridge_master #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .TIMEOUT_CYC(8)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_byte_en(cmd_byte_en), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_done(wr_done), .busy(busy),
    .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data)
  );

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                      input logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = model_read(a);
    for (int b = 0; b < BW; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[a] = v;
  endfunction

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Issues one command and plays the bridge: ack in strobe cycle ack_dly+1 (never if ack_dly<0).
  // pulse_at = index of first response pulse, counted from the cycle after accept.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] be,
                         input logic [DW-1:0] wd, input int ack_dly,
                         output int n_stb, output int n_rv, output int n_wd, output int n_er,
                         output int n_bad, output int pulse_at);
    int   guard;
    int   done_at;
    logic stb;
    n_stb = 0; n_rv = 0; n_wd = 0; n_er = 0; n_bad = 0; pulse_at = -1; done_at = -1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard == 20) n_bad++;
    cmd_write = wr; cmd_addr = a; cmd_byte_en = be; cmd_wdata = wd; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    for (int i = 0; i < 60; i++) begin
      stb = bus_read | bus_write;
      if (rsp_valid) n_rv++;
      if (wr_done) n_wd++;
      if (rsp_err) n_er++;
      if ((rsp_valid | wr_done | rsp_err) && pulse_at < 0) pulse_at = i;
      if (bus_read && bus_write) n_bad++;
      if (busy !== stb) n_bad++;
      if (stb) begin
        n_stb++;
        if (bus_write !== wr || bus_address !== a || bus_byte_enable !== be) n_bad++;
        if (wr && bus_write_data !== wd) n_bad++;
        if (cmd_ready) n_bad++;
      end else if (done_at < 0) begin
        done_at = i;
      end
      bus_acknowledge = stb && (ack_dly >= 0) && (n_stb == ack_dly + 1);
      bus_read_data   = bus_acknowledge ? model_read(a) : DW'($urandom);
      if (done_at >= 0 && i >= done_at + 2) break;
      step();
    end
    if (done_at < 0) n_bad++;
    bus_acknowledge = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ((|{cmd_ready, rsp_valid, rsp_err, wr_done, busy, bus_read, bus_write, bus_address,
           bus_byte_enable, bus_write_data, rsp_data}) !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs: some output nonzero, required all 0 (ready=%b busy=%b rd=%b wr=%b)",
               cmd_ready, busy, bus_read, bus_write);
    end
    reset_reset = 1'b0;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    int s, rv, wd, er, bad, pa;
    do_xfer(1'b1, 21'h00010, 2'b11, 16'hBEEF, 3, s, rv, wd, er, bad, pa);
    model_write(21'h00010, 2'b11, 16'hBEEF);
    n_cmp++;
    if (s !== 4) begin n_mis++; $display("FAIL write_strobe_len: got %0d required 4", s); end
    n_cmp++;
    if (wd !== 1 || rv !== 0 || er !== 0) begin
      n_mis++; $display("FAIL write_pulses: wr_done=%0d rsp_valid=%0d err=%0d required 1/0/0", wd, rv, er);
    end
    n_cmp++;
    if (pa !== 4) begin n_mis++; $display("FAIL write_pulse_time: got %0d required 4", pa); end
    n_cmp++;
    if (bad !== 0) begin n_mis++; $display("FAIL write_bus_stable: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_read();
    int s, rv, wd, er, bad, pa;
    logic [DW-1:0] exp_d;
    exp_d = model_read(21'h00010);
    do_xfer(1'b0, 21'h00010, 2'b11, 16'h0000, 2, s, rv, wd, er, bad, pa);
    n_cmp++;
    if (s !== 3) begin n_mis++; $display("FAIL read_strobe_len: got %0d required 3", s); end
    n_cmp++;
    if (rv !== 1 || wd !== 0 || er !== 0 || pa !== 3) begin
      n_mis++; $display("FAIL read_pulses: rv=%0d wd=%0d er=%0d at=%0d required 1/0/0 at 3", rv, wd, er, pa);
    end
    n_cmp++;
    if (rsp_data !== exp_d) begin n_mis++; $display("FAIL read_data: got %h required %h", rsp_data, exp_d); end
    n_cmp++;
    if (bad !== 0) begin n_mis++; $display("FAIL read_bus_stable: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic          t_wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [AW-1:0] t_ad [3] = '{21'h00010, 21'h00200, 21'h00300};
    logic [DW-1:0] t_wd [3] = '{16'h1111, 16'hA5C3, 16'h2222};
    int acc [3];
    int idx, nrv, nwd, nbad;
    logic stb, acc_now;
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp_a, exp_c;
    exp_a = model_read(t_ad[0]);
    exp_c = model_read(t_ad[2]);
    idx = 0; nrv = 0; nwd = 0; nbad = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    cmd_write = t_wr[0]; cmd_addr = t_ad[0]; cmd_wdata = t_wd[0]; cmd_byte_en = 2'b11;
    cmd_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (idx == 3 && k > acc[2] + 4) break;
      stb = bus_read | bus_write;
      if (rsp_valid) begin nrv++; got.push_back(rsp_data); end
      if (wr_done) nwd++;
      if (bus_read && bus_write) nbad++;
      if (busy && cmd_ready) nbad++;
      bus_acknowledge = stb;
      bus_read_data   = model_read(bus_address);
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) acc[idx] = k;
      step();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          cmd_write = t_wr[idx]; cmd_addr = t_ad[idx]; cmd_wdata = t_wd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    bus_acknowledge = 1'b0;
    cmd_valid = 1'b0;
    model_write(t_ad[1], 2'b11, t_wd[1]);
    n_cmp++;
    if (idx !== 3 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
      n_mis++; $display("FAIL b2b_spacing: accepts %0d at %0d,%0d,%0d required 3 spaced by 3",
                        idx, acc[0], acc[1], acc[2]);
    end
    n_cmp++;
    if (nrv !== 2 || nwd !== 1 || nbad !== 0) begin
      n_mis++; $display("FAIL b2b_pulses: rv=%0d wd=%0d bad=%0d required 2/1/0", nrv, nwd, nbad);
    end
    n_cmp++;
    if (got.size() !== 2 || got[0] !== exp_a || got[1] !== exp_c) begin
      n_mis++; $display("FAIL b2b_data: %0d responses, required %h then %h", got.size(), exp_a, exp_c);
    end
  endtask

  task automatic test_zero_be();
    int s, rv, wd, er, bad, pa;
    do_xfer(1'b1, 21'h00040, 2'b00, 16'h1234, 0, s, rv, wd, er, bad, pa);
    n_cmp++;
    if (s !== 0 || wd !== 1 || rv !== 0 || pa !== 0 || bad !== 0) begin
      n_mis++; $display("FAIL zero_be: stb=%0d wd=%0d rv=%0d at=%0d bad=%0d required 0/1/0/0/0",
                        s, wd, rv, pa, bad);
    end
  endtask

  task automatic test_spurious_ack();
    logic [6:0] obs;
    bus_acknowledge = 1'b1;
    bus_read_data   = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) bus_acknowledge = 1'b0;
      obs = {bus_read, bus_write, rsp_valid, wr_done, rsp_err, busy, cmd_ready};
      n_cmp++;
      if (obs !== 7'b0000001) begin
        n_mis++; $display("FAIL spurious_ack[%0d]: rd,wr,rv,wd,er,busy,ready=%b required 0000001", i, obs);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r0;
    int nrv;
    nrv = 0;
    r0  = rsp_data;
    cmd_write = 1'b0; cmd_addr = 21'h00010; cmd_byte_en = 2'b11; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    n_cmp++;
    if (bus_read !== 1'b1 || busy !== 1'b1) begin
      n_mis++; $display("FAIL rst_mid_busy: rd=%b busy=%b required 1/1", bus_read, busy);
    end
    reset_reset = 1'b1;
    step();
    if (rsp_valid) nrv++;
    n_cmp++;
    if ({bus_read, bus_write, busy, cmd_ready} !== 4'b0000) begin
      n_mis++; $display("FAIL rst_mid_strobe: rd,wr,busy,ready=%b required 0000",
                        {bus_read, bus_write, busy, cmd_ready});
    end
    reset_reset = 1'b0;
    step();
    if (rsp_valid) nrv++;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_mis++; $display("FAIL rst_mid_ready: got %b required 1", cmd_ready); end
    step();
    if (rsp_valid) nrv++;
    n_cmp++;
    if (nrv !== 0 || rsp_data !== 16'h0000) begin
      n_mis++; $display("FAIL rst_mid_rsp: rv=%0d data=%h (was %h) required 0 and 0000", nrv, rsp_data, r0);
    end
  endtask

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int s, rv, wd, er, bad, pa;
    logic [DW-1:0] prev, exp_d;
    prev = rsp_data;
    do_xfer(1'b0, 21'h00010, 2'b11, 16'h0, -1, s, rv, wd, er, bad, pa);
    n_cmp++;
    if (s !== 8 || er !== 1 || rv !== 0 || pa !== 8 || bad !== 0) begin
      n_mis++; $display("FAIL tmo_read: stb=%0d er=%0d rv=%0d at=%0d bad=%0d required 8/1/0/8/0",
                        s, er, rv, pa, bad);
    end
    n_cmp++;
    if (rsp_data !== prev) begin n_mis++; $display("FAIL tmo_data: got %h required %h", rsp_data, prev); end
    do_xfer(1'b1, 21'h00020, 2'b01, 16'h7777, -1, s, rv, wd, er, bad, pa);
    n_cmp++;
    if (s !== 8 || er !== 1 || wd !== 0) begin
      n_mis++; $display("FAIL tmo_write: stb=%0d er=%0d wd=%0d required 8/1/0", s, er, wd);
    end
    exp_d = model_read(21'h00010);
    do_xfer(1'b0, 21'h00010, 2'b11, 16'h0, 7, s, rv, wd, er, bad, pa);
    n_cmp++;
    if (s !== 8 || er !== 0 || rv !== 1 || rsp_data !== exp_d) begin
      n_mis++; $display("FAIL tmo_ack_wins: stb=%0d er=%0d rv=%0d data=%h required 8/0/1/%h",
                        s, er, rv, rsp_data, exp_d);
    end
  endtask
`endif

  task automatic test_random();
    int s, rv, wd, er, bad, pa, dly, exp_s;
    logic          wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d, exp_d;
    for (int t = 0; t < 25; t++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 15));
      be  = BW'($urandom_range(0, 3));
      d   = DW'($urandom);
      dly = $urandom_range(0, 4);
      exp_d = model_read(a);
      exp_s = (wr && be == 2'b00) ? 0 : dly + 1;
      do_xfer(wr, a, be, d, dly, s, rv, wd, er, bad, pa);
      if (wr) model_write(a, be, d);
      n_cmp++;
      if (s !== exp_s || pa !== exp_s || bad !== 0) begin
        n_mis++; $display("FAIL rand%0d_timing: stb=%0d at=%0d bad=%0d required %0d/%0d/0",
                          t, s, pa, bad, exp_s, exp_s);
      end
      n_cmp++;
      if (rv !== (wr ? 0 : 1) || wd !== (wr ? 1 : 0) || er !== 0) begin
        n_mis++; $display("FAIL rand%0d_pulses: rv=%0d wd=%0d er=%0d wr=%b", t, rv, wd, er, wr);
      end
      if (!wr) begin
        n_cmp++;
        if (rsp_data !== exp_d) begin
          n_mis++; $display("FAIL rand%0d_data: got %h required %h", t, rsp_data, exp_d);
        end
      end
    end
  endtask

  initial begin
    reset_reset     = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_addr        = '0;
    cmd_byte_en     = '0;
    cmd_wdata       = '0;
    bus_acknowledge = 1'b0;
    bus_read_data   = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_zero_be();
    test_spurious_ack();
    test_reset_mid();
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
